// File: rtl/btn_event_gen.sv
// btn_event_gen: turns a debounced button level into press/release/long/repeat strobes,
// a held level and a wrap-around press counter; every output is a flop.
module btn_event_gen #(
    parameter int unsigned LONG_CYCLES   = 50_000_000,
    parameter int unsigned REPEAT_CYCLES = 10_000_000,
    parameter int unsigned CNT_W         = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_in,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic       repeat_pulse,
    output logic       held,
    output logic [7:0] press_count
);
    typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES == 0 ? 0 : REPEAT_CYCLES - 1);
    state_t           state, state_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic [7:0]       count_n;
    logic             btn_q, btn_d, rise, fall;
    logic             press_n, release_n, long_n, repeat_n;
    // btn_q is the sample, btn_d its previous value: two edges from input to strobe
    assign rise = btn_q & ~btn_d;
    assign fall = ~btn_q & btn_d;
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        count_n   = press_count;
        press_n   = 1'b0;
        release_n = 1'b0;
        long_n    = 1'b0;
        repeat_n  = 1'b0;
        if (state == IDLE) begin
            if (rise) begin
                state_n = PRESSED;
                timer_n = '0;
                press_n = 1'b1;
                count_n = press_count + 8'd1;
            end
        end else if (fall) begin
            state_n   = IDLE;
            timer_n   = '0;
            release_n = 1'b1;
        end else if (state == PRESSED) begin
            if (timer == LONG_LAST) begin
                state_n = HELD;
                timer_n = '0;
                long_n  = 1'b1;
            end else begin
                timer_n = timer + CNT_W'(1);
            end
        end else if (REPEAT_CYCLES != 0) begin
            repeat_n = timer == REP_LAST;
            timer_n  = repeat_n ? '0 : timer + CNT_W'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            timer         <= '0;
            btn_q         <= 1'b0;
            btn_d         <= 1'b0;
            press_count   <= '0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
            held          <= 1'b0;
        end else begin
            state         <= state_n;
            timer         <= timer_n;
            btn_q         <= btn_in;
            btn_d         <= btn_q;
            press_count   <= count_n;
            press_pulse   <= press_n;
            release_pulse <= release_n;
            long_pulse    <= long_n;
            repeat_pulse  <= repeat_n;
            held          <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_btn_event_gen.sv
// tb_btn_event_gen: random and directed button activity against a history-based reference
// model, on a repeating instance and a repeat-disabled instance side by side.
module tb_btn_event_gen;
    localparam int L = 8;
    localparam int R = 3;
    logic       clk = 0, rst = 1, btn_in = 0;
    logic       pa, ra, la, qa, ha, pb, rb, lb, qb, hb;
    logic [7:0] ca, cb;
    int         n_chk = 0, n_pass = 0, age = 0, cnt = 0, n_long = 0, n_rep = 0;
    bit         hist[$];
    bit         b1, b2, e_press, e_rel, e_long, e_rep, e_held;

    btn_event_gen #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .btn_in(btn_in), .press_pulse(pa), .release_pulse(ra),
        .long_pulse(la), .repeat_pulse(qa), .held(ha), .press_count(ca));
    btn_event_gen #(.LONG_CYCLES(L), .REPEAT_CYCLES(0), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .btn_in(btn_in), .press_pulse(pb), .release_pulse(rb),
        .long_pulse(lb), .repeat_pulse(qb), .held(hb), .press_count(cb));

    always #5 clk = ~clk;

    // Model: age counts edges since the press strobe while the sampled level stays high
    always @(posedge clk) begin
        if (rst) begin
            hist.delete();
            hist.push_back(1'b0);
            hist.push_back(1'b0);
            {age, cnt} = '0;
            {e_press, e_rel, e_long, e_rep, e_held} = '0;
        end else begin
            b2 = hist[0];
            b1 = hist[1];
            e_press = b1 && !b2;
            e_rel = !b1 && b2;
            if (e_press) begin
                age = 0;
                cnt = (cnt + 1) % 256;
            end else if (b1) age++;
            e_held = b1;
            e_long = b1 && !e_press && age == L;
            e_rep = b1 && age > L && (age - L) % R == 0;
            hist.push_back(btn_in);
            void'(hist.pop_front());
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    endtask

    task automatic step(input bit b, input bit r);
        btn_in = b;
        rst = r;
        @(posedge clk);
        @(negedge clk);
        chk("press_a", pa, e_press);
        chk("release_a", ra, e_rel);
        chk("long_a", la, e_long);
        chk("repeat_a", qa, e_rep);
        chk("held_a", ha, e_held);
        chk("count_a", ca, cnt);
        chk("onehot_a", int'(pa) + int'(ra) + int'(la) + int'(qa) > 1, 0);
        chk("press_b", pb, e_press);
        chk("release_b", rb, e_rel);
        chk("long_b", lb, e_long);
        chk("repeat_b", qb, 0);
        chk("held_b", hb, e_held);
        chk("count_b", cb, cnt);
        n_long += int'(lb);
        n_rep += int'(qb);
    endtask

    task automatic hold(input bit b, input int n);
        for (int i = 0; i < n; i++) step(b, 1'b0);
    endtask

    initial begin
        step(0, 1);
        step(0, 1);
        chk("rst_count", ca, 0);
        chk("rst_held", ha, 0);
        hold(0, 8);
        hold(1, 5);
        hold(0, 6);
        hold(1, 20);
        hold(0, 5);
        hold(1, L);
        hold(0, 5);
        step(0, 1);
        for (int i = 0; i < 256; i++) begin
            hold(1, 1);
            hold(0, 1);
        end
        hold(0, 3);
        chk("wrap_zero", ca, 0);
        hold(1, 1);
        hold(0, 3);
        chk("wrap_one", ca, 1);
        hold(1, 16);
        step(1, 1);
        chk("midrst_held", ha, 0);
        chk("midrst_count", ca, 0);
        chk("midrst_rel", ra, 0);
        hold(1, 1);
        chk("post_rst_wait", pa, 0);
        hold(1, 1);
        chk("post_rst_press", pa, 1);
        hold(0, 4);
        {n_long, n_rep} = '0;
        hold(1, 30);
        hold(0, 4);
        chk("norep_longs", n_long, 1);
        chk("norep_repeats", n_rep, 0);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 19) == 0) step(1'($urandom_range(0, 1)), 1'b1);
            else hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 14)));
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
